// File: rtl/alu_sched_pkg.sv
// Shared definitions for the ALU operation scheduler: FSM states and the
// function codes that select the multi-cycle path.
package alu_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } sched_state_t;

    localparam logic [1:0] FC_ARITH = 2'b00;
    localparam logic [3:0] FUNC_MUL = 4'b0100;
    localparam logic [3:0] FUNC_DIV = 4'b0101;

endpackage

// File: rtl/alu_op_sched.sv
// Issues one operation at a time to an external ALU, stretches MUL/DIV to
// MULDIV_LAT execute cycles and holds the captured result until consumed.
//   state | meaning
//   IDLE  | no operation in flight, ready for a request
//   EXEC  | operands on the ALU, cnt counting down to capture
//   DONE  | result held on res_*, waiting for res_ready
module alu_op_sched
    import alu_sched_pkg::*;
#(
    parameter int MULDIV_LAT = 4,
    parameter int TAG_W      = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_fc,
    input  logic [3:0]       req_func,
    input  logic [15:0]      req_a,
    input  logic [15:0]      req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic [1:0]       alu_in_fc,
    output logic [3:0]       alu_func_c,
    output logic [15:0]      alu_in1,
    output logic [15:0]      alu_in2,
    input  logic [15:0]      alu_op,
    input  logic [15:0]      alu_r0,
    input  logic             alu_flag,
    input  logic             alu_oflw,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [15:0]      res_op,
    output logic [15:0]      res_r0,
    output logic             res_r0_we,
    output logic             res_flag,
    output logic             res_oflw,
    output logic             res_dz,
    output logic [TAG_W-1:0] res_tag,
    output logic             busy
);

    localparam logic [3:0] LAT_M1 = 4'(MULDIV_LAT - 1);

    sched_state_t r_state;
    sched_state_t w_next;

    logic [1:0]       r_fc;
    logic [3:0]       r_func;
    logic [15:0]      r_a;
    logic [15:0]      r_b;
    logic [TAG_W-1:0] r_tag;
    logic [3:0]       r_cnt;

    logic [15:0]      r_res_op;
    logic [15:0]      r_res_r0;
    logic             r_res_r0_we;
    logic             r_res_flag;
    logic             r_res_oflw;
    logic             r_res_dz;
    logic [TAG_W-1:0] r_res_tag;

    logic w_accept;
    logic w_req_muldiv;
    logic w_reg_muldiv;
    logic w_div_zero;
    logic w_capture;

    always_comb begin
        w_req_muldiv = (req_fc == FC_ARITH) &&
                       ((req_func == FUNC_MUL) || (req_func == FUNC_DIV));
        w_reg_muldiv = (r_fc == FC_ARITH) &&
                       ((r_func == FUNC_MUL) || (r_func == FUNC_DIV));
        // Divide by zero short-circuits the multi-cycle wait.
        w_div_zero   = (r_fc == FC_ARITH) && (r_func == FUNC_DIV) && (r_b == 16'h0000);
        w_capture    = (r_state == ST_EXEC) && ((r_cnt == 4'd0) || w_div_zero);

        w_next    = r_state;
        req_ready = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) w_next = ST_EXEC;
            end
            ST_EXEC: begin
                if (w_capture) w_next = ST_DONE;
            end
            ST_DONE: begin
                req_ready = res_ready;
                if (res_ready) w_next = req_valid ? ST_EXEC : ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
        w_accept = req_valid && req_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fc        <= '0;
            r_func      <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_tag       <= '0;
            r_cnt       <= '0;
            r_res_op    <= '0;
            r_res_r0    <= '0;
            r_res_r0_we <= 1'b0;
            r_res_flag  <= 1'b0;
            r_res_oflw  <= 1'b0;
            r_res_dz    <= 1'b0;
            r_res_tag   <= '0;
        end else begin
            if (w_accept) begin
                r_fc   <= req_fc;
                r_func <= req_func;
                r_a    <= req_a;
                r_b    <= req_b;
                r_tag  <= req_tag;
                r_cnt  <= w_req_muldiv ? LAT_M1 : 4'd0;
            end else if ((r_state == ST_EXEC) && !w_capture) begin
                r_cnt <= r_cnt - 4'd1;
            end

            if (w_capture) begin
                r_res_tag <= r_tag;
                if (w_div_zero) begin
                    r_res_op    <= 16'h0000;
                    r_res_r0    <= 16'h0000;
                    r_res_r0_we <= 1'b0;
                    r_res_flag  <= 1'b0;
                    r_res_oflw  <= 1'b0;
                    r_res_dz    <= 1'b1;
                end else begin
                    r_res_op    <= alu_op;
                    r_res_r0    <= alu_r0;
                    r_res_r0_we <= w_reg_muldiv;
                    r_res_flag  <= alu_flag;
                    r_res_oflw  <= alu_oflw;
                    r_res_dz    <= 1'b0;
                end
            end
        end
    end

    assign alu_in_fc  = r_fc;
    assign alu_func_c = r_func;
    assign alu_in1    = r_a;
    assign alu_in2    = r_b;

    assign res_valid  = (r_state == ST_DONE);
    assign res_op     = r_res_op;
    assign res_r0     = r_res_r0;
    assign res_r0_we  = r_res_r0_we;
    assign res_flag   = r_res_flag;
    assign res_oflw   = r_res_oflw;
    assign res_dz     = r_res_dz;
    assign res_tag    = r_res_tag;
    assign busy       = (r_state != ST_IDLE);

endmodule

// File: doc/alu_op_sched.md
ALU_OP_SCHED -- requirements
Module: alu_op_sched

Interface
REQ-001 Parameter: MULDIV_LAT, default 4, execute-cycle count for multiply/divide ops (legal 1..15).
REQ-002 Parameter: TAG_W, default 3, width of the request tag.
REQ-003 Port: clk  input  1  single clock; every register updates on its rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: req_valid  input  1  an operation is offered.
REQ-006 Port: req_ready  output  1  the scheduler accepts the offered operation this cycle.
REQ-007 Port: req_fc / req_func / req_a / req_b / req_tag  input  2/4/16/16/TAG_W  instruction class, function code, operand 1, operand 2 and tag.
REQ-008 Port: alu_in_fc / alu_func_c / alu_in1 / alu_in2  output  2/4/16/16  drive the external ALU.
REQ-009 Port: alu_op / alu_r0 / alu_flag / alu_oflw  input  16/16/1/1  ALU primary result, R0 side result, flag and overflow.
REQ-010 Port: res_valid  output  1  a result is held.
REQ-011 Port: res_ready  input  1  the consumer takes the result.
REQ-012 Port: res_op / res_r0 / res_r0_we / res_flag / res_oflw / res_dz / res_tag  output  16/16/1/1/1/1/TAG_W  captured result, R0 write enable, status bits and tag.
REQ-013 Port: busy  output  1  the scheduler is not in IDLE.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, EXEC and DONE.
REQ-015 req_ready SHALL be 1 in IDLE, equal res_ready in DONE, and be 0 in EXEC.
REQ-016 An accept (req_valid && req_ready) SHALL register all request fields, enter EXEC and load cnt.
  - MULDIV_LAT-1 when the op is multi-cycle.
  - 0 otherwise.
REQ-017 An op SHALL be multi-cycle only when req_fc=2'b00 and req_func is 4'b0100 (MUL) or 4'b0101 (DIV).
REQ-018 The alu_* outputs SHALL always drive the registered operand/code fields and SHALL change only on an accept.
REQ-019 In EXEC with cnt>0, cnt SHALL decrement each cycle and no capture SHALL occur.
REQ-020 In EXEC with cnt==0, the block SHALL capture the result and enter DONE the next cycle.
  - alu_op, alu_r0, alu_flag and alu_oflw into res_op, res_r0, res_flag and res_oflw.
  - res_r0_we=1 only for MUL/DIV; res_dz=0.
REQ-021 Latency from the accept cycle T to the first res_valid cycle SHALL be 2 for single-cycle ops and MULDIV_LAT+1 for MUL/DIV.
REQ-022 A DIV with registered operand 2 equal to 0 SHALL capture in the first EXEC cycle regardless of cnt.
  - Captured values: res_op=0, res_r0=0, res_dz=1, res_r0_we=0, res_flag=0, res_oflw=0.
REQ-023 res_valid SHALL be 1 exactly in DONE, and all res_* outputs SHALL hold stable until res_ready=1.
REQ-024 In DONE with res_ready=1, the next state SHALL be EXEC if req_valid=1 (simultaneous release and accept, no bubble), else IDLE.
REQ-025 res_valid SHALL never be 1 in the cycle immediately after an accept.
REQ-026 busy SHALL equal (state != IDLE).

Reset
REQ-027 While rst=1, the next state SHALL be IDLE and cnt=0.
REQ-028 While rst=1, all registered operand/code fields, all res_* outputs and busy SHALL be 0.
REQ-029 rst SHALL take priority over req_valid and res_ready.
REQ-030 A reset asserted in EXEC or DONE SHALL discard the in-flight operation, which SHALL never appear on res_valid.
REQ-031 req_ready SHALL be 1 in the first cycle after rst deasserts.

Structure
REQ-032 Package alu_sched_pkg SHALL hold the following, and nothing else shared.
  - The state enum.
  - The constants FC_ARITH=2'b00, FUNC_MUL=4'b0100 and FUNC_DIV=4'b0101.
REQ-033 The ALU SHALL be instantiated by the parent, not inside this block, and the block SHALL contain no sub-module; the counter and FSM SHALL be local.

Verification
REQ-034 Bench SHALL cover: DIV 0x0014/0x0010 accepted at T, MULDIV_LAT=4 -> res_valid at T+5, res_op=0x0001, res_r0=0x0004, res_r0_we=1.
REQ-035 Bench SHALL cover: DIV 0x0014/0x0000 -> res_valid at T+2, res_dz=1, res_op=0x0000, res_r0_we=0.
REQ-036 Bench SHALL cover: MUL 0x800B*0x0008 -> res_valid at T+5, res_op=0x8058, res_oflw=1.
REQ-037 Bench SHALL cover: back-to-back single-cycle ops with res_ready held 1 and req_valid held 1 -> one result every 2 cycles, tags in order.
REQ-038 Bench SHALL cover: res_ready held 0 for 5 cycles in DONE -> res_* stable, req_ready=0, and no second accept occurs.
REQ-039 Bench SHALL cover: rst pulsed during EXEC of a MUL -> res_valid stays 0, outputs read 0 during reset, and req_ready=1 the cycle after.
